mc_core_ctrl: RTL and testbench



---
 rtl/mc_core_ctrl_pkg.sv | 18 +
 rtl/mc_core_ctrl_if.sv | 39 +++
 rtl/mc_core_ctrl_bus_port.sv | 57 +++++
 rtl/mc_core_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_core_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_core_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control core.
// The state encoding is fixed so trace tools can decode fsm_state directly.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    IF_REQ   = 3'd0,
    IF_WAIT  = 3'd1,
    ID       = 3'd2,
    EXE      = 3'd3,
    MEM_REQ  = 3'd4,
    MEM_WAIT = 3'd5,
    WB       = 3'd6
  } state_t;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

endpackage

// File: rtl/mc_core_ctrl_if.sv
// Instruction and data SRAM-like buses between the control core and the bridge.
// Handshake: the master raises req with addr/wr/wdata and holds all of them
// unchanged until the slave answers addr_ok in the same cycle (address
// accepted). Data returns later as a one-cycle data_ok with rdata; data_ok is
// never sampled in the cycle of its own addr_ok, and only while the master waits.
interface mc_core_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mc_core_ctrl_bus_port.sv
// One request/response channel: drives req and payload while the core issues,
// tracks the outstanding request, and turns data_ok into a one-cycle resp_valid.
module mc_bus_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_i,
  input  logic              wait_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              addr_ok_i,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              accept_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o
);

  logic pend_q, pend_d;

  // Payload comes from core registers frozen during the request state, so it
  // stays constant until addr_ok; outside a request every line reads zero.
  assign req_o   = issue_i & ~reset;
  assign addr_o  = req_o ? addr_i  : '0;
  assign wr_o    = req_o & wr_i;
  assign wdata_o = req_o ? wdata_i : '0;

  assign accept_o     = req_o & addr_ok_i;
  // pend_q is only set after the accepting edge, so a same-cycle data_ok is dropped.
  assign resp_valid_o = pend_q & wait_i & data_ok_i & ~reset;
  assign resp_data_o  = resp_valid_o ? rdata_i : '0;

  always_comb begin
    pend_d = pend_q;
    if (accept_o) begin
      pend_d = 1'b1;
    end else if (resp_valid_o) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/mc_core_ctrl.sv
// Control and sequencing core of the multi-cycle CPU: PC, IR, stage FSM,
// retirement counter, and the fetch/data bus ports.
module mc_core_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_core_ctrl_if.master    bus,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_is_br,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_gr_we,
  input  logic [4:0]        dec_dest,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       instret,
  output logic [ADDR_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output state_t            fsm_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [DATA_W-1:0] ir_q, ir_d, alu_q, alu_d, sd_q, sd_d, ld_q, ld_d;
  logic [31:0]       instret_q, instret_d;
  logic              retire;

  logic              inst_issue, inst_wait, data_issue, data_wait, wb_active;
  logic              inst_accept, inst_resp, data_accept, data_resp;
  logic [DATA_W-1:0] inst_resp_data, data_resp_data;
  logic              inst_wr_unused;
  logic [DATA_W-1:0] inst_wdata_unused;

  mc_bus_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst_port (
    .clk          (clk),
    .reset        (reset),
    .issue_i      (inst_issue),
    .wait_i       (inst_wait),
    .addr_i       (pc_q),
    .wr_i         (1'b0),
    .wdata_i      ({DATA_W{1'b0}}),
    .req_o        (bus.inst_req),
    .addr_o       (bus.inst_addr),
    .wr_o         (inst_wr_unused),
    .wdata_o      (inst_wdata_unused),
    .addr_ok_i    (bus.inst_addr_ok),
    .data_ok_i    (bus.inst_data_ok),
    .rdata_i      (bus.inst_rdata),
    .accept_o     (inst_accept),
    .resp_valid_o (inst_resp),
    .resp_data_o  (inst_resp_data)
  );

  mc_bus_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_port (
    .clk          (clk),
    .reset        (reset),
    .issue_i      (data_issue),
    .wait_i       (data_wait),
    .addr_i       (ADDR_W'(alu_q)),
    .wr_i         (dec_is_store),
    .wdata_i      (sd_q),
    .req_o        (bus.data_req),
    .addr_o       (bus.data_addr),
    .wr_o         (bus.data_wr),
    .wdata_o      (bus.data_wdata),
    .addr_ok_i    (bus.data_addr_ok),
    .data_ok_i    (bus.data_data_ok),
    .rdata_i      (bus.data_rdata),
    .accept_o     (data_accept),
    .resp_valid_o (data_resp),
    .resp_data_o  (data_resp_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IF_REQ;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      npc_q     <= '0;
      alu_q     <= '0;
      sd_q      <= '0;
      ld_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      alu_q     <= alu_d;
      sd_q      <= sd_d;
      ld_q      <= ld_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_REQ:   if (inst_accept) state_d = IF_WAIT;
      IF_WAIT:  if (inst_resp) state_d = ID;
      ID:       state_d = dec_is_br ? IF_REQ : EXE;
      EXE:      state_d = (dec_is_load | dec_is_store) ? MEM_REQ : WB;
      MEM_REQ:  if (data_accept) state_d = MEM_WAIT;
      MEM_WAIT: if (data_resp) state_d = dec_is_store ? IF_REQ : WB;
      WB:       state_d = IF_REQ;
      default:  state_d = IF_REQ;
    endcase
  end

  always_comb begin
    inst_issue = 1'b0;
    inst_wait  = 1'b0;
    data_issue = 1'b0;
    data_wait  = 1'b0;
    wb_active  = 1'b0;
    case (state_q)
      IF_REQ:   inst_issue = 1'b1;
      IF_WAIT:  inst_wait  = 1'b1;
      MEM_REQ:  data_issue = 1'b1;
      MEM_WAIT: data_wait  = 1'b1;
      WB:       wb_active  = ~reset;
      default:  ;
    endcase
  end

  // Register updates and retirement; every retire point also commits the PC.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    npc_d     = npc_q;
    alu_d     = alu_q;
    sd_d      = sd_q;
    ld_d      = ld_q;
    instret_d = instret_q;
    retire    = 1'b0;
    case (state_q)
      IF_WAIT: if (inst_resp) ir_d = inst_resp_data;
      ID: begin
        npc_d = br_taken ? br_target : pc_q + ADDR_W'(INST_BYTES);
        if (dec_is_br) begin
          pc_d   = npc_d;
          retire = 1'b1;
        end
      end
      EXE: begin
        alu_d = exe_result;
        sd_d  = store_data;
      end
      MEM_WAIT: begin
        if (data_resp) begin
          if (dec_is_store) begin
            pc_d   = npc_q;
            retire = 1'b1;
          end else begin
            ld_d = data_resp_data;
          end
        end
      end
      WB: begin
        pc_d   = npc_q;
        retire = 1'b1;
      end
      default: ;
    endcase
    if (retire) begin
      instret_d = instret_q + 32'd1;
    end
  end

  assign rf_we    = wb_active & dec_gr_we;
  assign rf_waddr = wb_active ? dec_dest : 5'd0;
  assign rf_wdata = wb_active ? (dec_is_load ? ld_q : alu_q) : '0;

  assign debug_wb_pc       = wb_active ? pc_q : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  assign ir        = ir_q;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Directed bench for mc_core_ctrl: a program table drives a wait-state bus
// responder and a decoder stub; a latency/PC model is checked every cycle.
module tb_mc_core_ctrl;
  import mc_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NPROG = 9;
  localparam int C_ALU = 0;
  localparam int C_BR  = 1;
  localparam int C_LD  = 2;
  localparam int C_ST  = 3;

  typedef struct {
    int          cls;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] exe;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        gr_we;
    logic [4:0]  dest;
    int          ia_w;
    int          id_w;
    int          da_w;
    int          dd_w;
  } instr_t;

  instr_t prog [16];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_core_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [DW-1:0] ir, exe_result, store_data, rf_wdata, debug_wb_rf_wdata;
  logic [AW-1:0] pc, br_target, debug_wb_pc;
  logic          dec_is_br, dec_is_load, dec_is_store, dec_gr_we, br_taken, rf_we;
  logic [4:0]    dec_dest, rf_waddr, debug_wb_rf_wnum;
  logic [31:0]   instret;
  logic [3:0]    debug_wb_rf_we;
  state_t        fsm_state;

  mc_core_ctrl #(.RESET_PC(32'h1c00_0000), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .ir                (ir),
    .pc                (pc),
    .dec_is_br         (dec_is_br),
    .dec_is_load       (dec_is_load),
    .dec_is_store      (dec_is_store),
    .dec_gr_we         (dec_gr_we),
    .dec_dest          (dec_dest),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .exe_result        (exe_result),
    .store_data        (store_data),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .instret           (instret),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .fsm_state         (fsm_state)
  );

  // Decoder stub: the low nibble of ir selects the program entry.
  always_comb begin
    dec_is_br    = (prog[ir[3:0]].cls == C_BR);
    dec_is_load  = (prog[ir[3:0]].cls == C_LD);
    dec_is_store = (prog[ir[3:0]].cls == C_ST);
    dec_gr_we    = prog[ir[3:0]].gr_we;
    dec_dest     = prog[ir[3:0]].dest;
    br_taken     = prog[ir[3:0]].br_taken;
    br_target    = prog[ir[3:0]].br_target;
    exe_result   = prog[ir[3:0]].exe;
    store_data   = prog[ir[3:0]].sd;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input int cls, input logic tk, input logic [31:0] tgt,
                                input logic [31:0] exe, input logic [31:0] sd,
                                input logic [31:0] rd, input logic we, input logic [4:0] dst,
                                input int ia, input int idw, input int da, input int dd);
    instr_t t;
    t.cls = cls; t.br_taken = tk; t.br_target = tgt; t.exe = exe; t.sd = sd;
    t.rdata = rd; t.gr_we = we; t.dest = dst;
    t.ia_w = ia; t.id_w = idw; t.da_w = da; t.dd_w = dd;
    return t;
  endfunction

  function automatic logic [31:0] word_of(input int k);
    logic [3:0] kk;
    logic [1:0] c;
    kk = 4'(k);
    c  = 2'(prog[k].cls);
    return {c, 26'd0, kk};
  endfunction

  // Stage counts: fetch takes 2 cycles plus waits; then ID, EXE, MEM_REQ, MEM_WAIT, WB.
  function automatic int fetch_cycles(input int k);
    return prog[k].ia_w + prog[k].id_w + 2;
  endfunction

  function automatic int latency(input int k);
    int f;
    f = fetch_cycles(k);
    case (prog[k].cls)
      C_BR:    return f + 1;
      C_ALU:   return f + 3;
      C_ST:    return f + prog[k].da_w + prog[k].dd_w + 4;
      default: return f + prog[k].da_w + prog[k].dd_w + 5;
    endcase
  endfunction

  // ---------------- per-cycle model compare ----------------
  logic        mdl_run = 1'b0;
  int          mdl_k   = 0;
  int          mdl_cyc = 0;
  logic [31:0] mdl_pc  = 32'h1c00_0000;
  logic [31:0] mdl_ret = 32'd0;
  int          m_fetch, m_lat;
  logic        m_mem, m_rf, m_dreq;
  logic [31:0] m_wdata;

  always @(negedge clk) begin
    if (mdl_run && mdl_k < NPROG) begin
      m_fetch = fetch_cycles(mdl_k);
      m_lat   = latency(mdl_k);
      m_mem   = (prog[mdl_k].cls == C_LD) || (prog[mdl_k].cls == C_ST);
      m_rf    = (prog[mdl_k].cls == C_LD || prog[mdl_k].cls == C_ALU) && prog[mdl_k].gr_we
                && (mdl_cyc == m_lat - 1);
      m_dreq  = m_mem && (mdl_cyc >= m_fetch + 2) && (mdl_cyc <= m_fetch + 2 + prog[mdl_k].da_w);
      m_wdata = (prog[mdl_k].cls == C_LD) ? prog[mdl_k].rdata : prog[mdl_k].exe;

      check("pc", pc, mdl_pc);
      check("instret", instret, mdl_ret);
      check("inst_req", bus.inst_req, (mdl_cyc <= prog[mdl_k].ia_w));
      if (bus.inst_req) check("inst_addr", bus.inst_addr, mdl_pc);
      check("data_req", bus.data_req, m_dreq);
      if (m_dreq) begin
        check("data_addr", bus.data_addr, prog[mdl_k].exe);
        check("data_wr", bus.data_wr, (prog[mdl_k].cls == C_ST));
        check("data_wdata", bus.data_wdata, prog[mdl_k].sd);
      end
      check("rf_we", rf_we, m_rf);
      check("debug_wb_rf_we", debug_wb_rf_we, m_rf ? 4'hf : 4'h0);
      if (m_rf) begin
        check("rf_waddr", rf_waddr, prog[mdl_k].dest);
        check("rf_wdata", rf_wdata, m_wdata);
        check("debug_wb_pc", debug_wb_pc, mdl_pc);
        check("debug_wb_rf_wnum", debug_wb_rf_wnum, prog[mdl_k].dest);
        check("debug_wb_rf_wdata", debug_wb_rf_wdata, m_wdata);
      end

      mdl_cyc++;
      if (mdl_cyc == m_lat) begin
        mdl_pc  = prog[mdl_k].br_taken ? prog[mdl_k].br_target : mdl_pc + 32'd4;
        mdl_ret = mdl_ret + 32'd1;
        mdl_k++;
        mdl_cyc = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_inst_req();
    int n;
    n = 0;
    while (bus.inst_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("inst_req_seen", bus.inst_req, 1'b1);
  endtask

  task automatic wait_data_req();
    int n;
    n = 0;
    while (bus.data_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("data_req_seen", bus.data_req, 1'b1);
  endtask

  task automatic run_instr(input int k);
    wait_inst_req();
    repeat (prog[k].ia_w) @(negedge clk);
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    repeat (prog[k].id_w) @(negedge clk);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = word_of(k);
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    if (prog[k].cls == C_LD || prog[k].cls == C_ST) begin
      wait_data_req();
      for (int i = 0; i < prog[k].da_w; i++) begin
        // Stray responses while no request is outstanding must be ignored.
        if (prog[k].cls == C_LD && i == 0) bus.inst_data_ok = 1'b1;
        if (prog[k].cls == C_LD && i == 1) begin
          bus.data_data_ok = 1'b1;
          bus.data_rdata   = 32'h0bad_0bad;
        end
        @(negedge clk);
        bus.inst_data_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
      end
      bus.data_addr_ok = 1'b1;
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      repeat (prog[k].dd_w) @(negedge clk);
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = prog[k].rdata;
      @(negedge clk);
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = '0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    prog[0] = mk(C_ALU, 1'b0, 32'h0,          32'h0000_0055, 32'h0,          32'h0,          1'b1, 5'd5,  0, 0, 0, 0);
    prog[1] = mk(C_BR,  1'b1, 32'h1c00_0100,  32'h0,         32'h0,          32'h0,          1'b0, 5'd0,  0, 0, 0, 0);
    prog[2] = mk(C_LD,  1'b0, 32'h0,          32'h1c00_8000, 32'h0,          32'hdead_beef,  1'b1, 5'd7,  0, 0, 3, 1);
    prog[3] = mk(C_ST,  1'b0, 32'h0,          32'h1c00_8010, 32'h1234_5678,  32'h0,          1'b0, 5'd0,  1, 0, 2, 0);
    prog[4] = mk(C_ALU, 1'b0, 32'h0,          32'h0000_0077, 32'h0,          32'h0,          1'b0, 5'd9,  0, 2, 0, 0);
    prog[5] = mk(C_BR,  1'b0, 32'h1c00_0400,  32'h0,         32'h0,          32'h0,          1'b0, 5'd0,  0, 0, 0, 0);
    prog[6] = mk(C_ALU, 1'b0, 32'h0,          32'hffff_ffff, 32'h0,          32'h0,          1'b1, 5'd31, 2, 1, 0, 0);
    prog[7] = mk(C_BR,  1'b1, 32'hffff_fffc,  32'h0,         32'h0,          32'h0,          1'b0, 5'd0,  0, 0, 0, 0);
    prog[8] = mk(C_ALU, 1'b0, 32'h0,          32'h0000_0001, 32'h0,          32'h0,          1'b1, 5'd1,  0, 0, 0, 0);
    prog[9] = mk(C_LD,  1'b0, 32'h0,          32'h1c00_8020, 32'h0,          32'hcafe_f00d,  1'b1, 5'd3,  0, 0, 0, 0);
    for (int i = 10; i < 16; i++) prog[i] = mk(C_ALU, 1'b0, 0, 0, 0, 0, 1'b0, 5'd0, 0, 0, 0, 0);

    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_state", fsm_state, IF_REQ);
    check("rst_pc", pc, 32'h1c00_0000);
    check("rst_ir", ir, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_inst_req", bus.inst_req, 1'b0);
    check("rst_inst_addr", bus.inst_addr, 32'h0);
    check("rst_data_req", bus.data_req, 1'b0);
    check("rst_data_addr", bus.data_addr, 32'h0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_debug_we", debug_wb_rf_we, 4'h0);

    @(posedge clk);
    #1;
    reset   = 1'b0;
    mdl_run = 1'b1;
    @(negedge clk);
    check("first_inst_req", bus.inst_req, 1'b1);
    check("first_inst_addr", bus.inst_addr, 32'h1c00_0000);

    for (int k = 0; k < NPROG; k++) run_instr(k);

    n = 0;
    while (mdl_k < NPROG && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("model_done", mdl_k, NPROG);
    @(negedge clk);
    mdl_run = 1'b0;

    // pc+4 from 0xfffffffc wraps to zero; nine instructions retired.
    check("end_inst_req", bus.inst_req, 1'b1);
    check("end_inst_addr", bus.inst_addr, 32'h0);
    check("end_pc", pc, 32'h0);
    check("end_instret", instret, 32'd9);

    // Load at pc 0, then reset while its data is outstanding.
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = word_of(9);
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    wait_data_req();
    check("mid_data_addr", bus.data_addr, 32'h1c00_8020);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    check("mid_state_wait", fsm_state, MEM_WAIT);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_state", fsm_state, IF_REQ);
    check("mid_rst_data_req", bus.data_req, 1'b0);
    check("mid_rst_pc", pc, 32'h1c00_0000);
    check("mid_rst_instret", instret, 32'h0);
    check("mid_rst_rf_we", rf_we, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_inst_req", bus.inst_req, 1'b1);
    check("post_rst_inst_addr", bus.inst_addr, 32'h1c00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
